cla_adder_pipe2: RTL

//   Two-stage pipelined 32-bit add/subtract unit for the EX stage ALU. It wraps the 4-bit carry_lookahead4 units in a two-level lookahead tree.

---
 rtl/cla_adder_pipe2.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe2.sv
// cla_adder_pipe2: two-stage pipelined WIDTH-bit add/subtract built from a two-level carry-lookahead tree
// Ports: clk, rst_n (async, active-low), flush (sync pipeline kill)
//   operand side: in_valid, in_ready, a, b, sub (1 = a-b)
//   result side:  out_valid, out_ready, sum, cout, overflow (signed), zero

// carry_lookahead4: prefix propagate/generate of a 4-bit group; pp[i]/gp[i] span bits i..0
module carry_lookahead4 (
   input  logic [3:0] p,
   input  logic [3:0] g,
   output logic [3:0] pp,
   output logic [3:0] gp
);
   assign pp = {&p, &p[2:0], &p[1:0], p[0]};
   assign gp = {g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]),
                g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]),
                g[1] | (p[1] & g[0]),
                g[0]};
endmodule

module cla_adder_pipe2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);
   localparam int NN = WIDTH / 4;
   localparam int NG = WIDTH / 16;
   logic             out_adv, s1_adv, accept, out_load;
   logic [WIDTH-1:0] beff, p_d, g_d, pp_d, gp_d;
   logic             s1_valid_d, s1_valid_q, s1_ci_q;
   logic [WIDTH-1:0] s1_p_q, s1_pp_q, s1_gp_q;
   logic [NG*4-1:0]  l2_pp, l2_gp;
   logic [NN-1:0]    cn;
   logic [WIDTH:0]   c;
   logic             cg;
   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q, overflow_d, overflow_q, zero_d, zero_q;
   assign out_adv  = !out_valid_q | out_ready;
   assign s1_adv   = !s1_valid_q | out_adv;
   assign in_ready = s1_adv & !flush;
   assign accept   = in_valid & in_ready;
   assign out_load = out_adv & s1_valid_q;
   always_comb begin
      beff        = sub ? ~b : b;
      p_d         = a ^ beff;
      g_d         = a & beff;
      s1_valid_d  = flush ? 1'b0 : (s1_adv ? accept : s1_valid_q);
      out_valid_d = flush ? 1'b0 : (out_adv ? s1_valid_q : out_valid_q);
   end
   for (genvar n = 0; n < NN; n++) begin : g_nib
      carry_lookahead4 u_cla (
         .p (p_d[4*n +: 4]),
         .g (g_d[4*n +: 4]),
         .pp(pp_d[4*n +: 4]),
         .gp(gp_d[4*n +: 4])
      );
   end
   // Level 2: bit 3 of each nibble's prefix terms is that nibble's P*/G*
   for (genvar k = 0; k < NG; k++) begin : g_grp
      carry_lookahead4 u_cla (
         .p ({s1_pp_q[16*k+15], s1_pp_q[16*k+11], s1_pp_q[16*k+7], s1_pp_q[16*k+3]}),
         .g ({s1_gp_q[16*k+15], s1_gp_q[16*k+11], s1_gp_q[16*k+7], s1_gp_q[16*k+3]}),
         .pp(l2_pp[4*k +: 4]),
         .gp(l2_gp[4*k +: 4])
      );
   end
   // Carry into position j of a group is prefix(j-1) applied to the group carry-in;
   // 16-bit groups ripple their carry to the next group
   always_comb begin
      cg = s1_ci_q;
      cn = '0;
      for (int k = 0; k < NG; k++) begin
         cn[4*k +: 4] = {l2_gp[4*k +: 3], 1'b0} | ({l2_pp[4*k +: 3], 1'b1} & {4{cg}});
         cg = l2_gp[4*k+3] | (l2_pp[4*k+3] & cg);
      end
      c = '0;
      for (int n = 0; n < NN; n++)
         c[4*n +: 4] = {s1_gp_q[4*n +: 3], 1'b0} | ({s1_pp_q[4*n +: 3], 1'b1} & {4{cn[n]}});
      c[WIDTH]   = cg;
      sum_d      = s1_p_q ^ c[WIDTH-1:0];
      cout_d     = c[WIDTH];
      overflow_d = c[WIDTH-1] ^ c[WIDTH];
      zero_d     = ~|sum_d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_ci_q     <= 1'b0;
         s1_p_q      <= '0;
         s1_pp_q     <= '0;
         s1_gp_q     <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         if (accept) begin
            s1_ci_q <= sub;
            s1_p_q  <= p_d;
            s1_pp_q <= pp_d;
            s1_gp_q <= gp_d;
         end
         if (out_load) begin
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
         end
      end
   end
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
endmodule
